// File: rtl/pfile_loader_if.sv
// pfile_loader_if
//   Bus bundle between the .P loader and its neighbours.
//   buf_addr/buf_dout : download-buffer read port (data one clk after address)
//   hold_req/hold_ack : CPU bus hold handshake
//   mem_addr/mem_dout/mem_we : system RAM write port
//   master = loader side, slave = buffer/CPU/RAM side.
interface pfile_loader_if #(
   parameter int BUF_AW = 14
);
   logic [BUF_AW-1:0] buf_addr;
   logic [7:0]        buf_dout;
   logic              hold_req;
   logic              hold_ack;
   logic [15:0]       mem_addr;
   logic [7:0]        mem_dout;
   logic              mem_we;

   modport master (
      output buf_addr, hold_req, mem_addr, mem_dout, mem_we,
      input  buf_dout, hold_ack
   );

   modport slave (
      input  buf_addr, hold_req, mem_addr, mem_dout, mem_we,
      output buf_dout, hold_ack
   );
endinterface

// File: rtl/pfile_loader.sv
// pfile_loader
//   Copies a downloaded .P image from the SPI download buffer into system RAM
//   at LOAD_ADDR once the download ends, holding the Z80 off the bus for the
//   duration, then releases the CPU and pulses done.
// Ports
//   clk, reset_n : system clock, async active-low reset
//   downloading  : download-active flag from the SPI domain (asynchronous)
//   size         : bytes received, stable while downloading is low
//   bus          : buffer read port, CPU hold handshake, RAM write port
//   busy         : high in every state except IDLE
//   done         : one-clk pulse after a complete copy
//   truncated    : sticky, last size exceeded buffer capacity
module pfile_loader #(
   parameter logic [15:0] LOAD_ADDR = 16'h4009,
   parameter int          BUF_AW    = 14
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 downloading,
   input  logic [15:0]          size,
   pfile_loader_if.master       bus,
   output logic                 busy,
   output logic                 done,
   output logic                 truncated
);
   localparam int          LW  = BUF_AW + 1;
   localparam logic [16:0] CAP = 17'd1 << BUF_AW;

   typedef enum logic [2:0] {IDLE, REQ, RD, WT, WR, REL, DONE} state_t;

   state_t          state;
   logic            dl_s1, dl_s2, dl_s3;
   logic [LW-1:0]   len, idx;
   logic [LW-1:0]   idx_nx;
   logic [16:0]     size_x;
   logic            over;
   logic            trig;

   assign idx_nx = idx + 1'b1;
   assign size_x = {1'b0, size};
   assign over   = size_x > CAP;
   // dl_s2 is the synchronised flag; dl_s3 is its previous value for edge detect
   assign trig   = dl_s3 & ~dl_s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_s1        <= 1'b0;
         dl_s2        <= 1'b0;
         dl_s3        <= 1'b0;
         state        <= IDLE;
         len          <= '0;
         idx          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         truncated    <= 1'b0;
         bus.buf_addr <= '0;
         bus.hold_req <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_dout <= '0;
         bus.mem_we   <= 1'b0;
      end else begin
         dl_s1 <= downloading;
         dl_s2 <= dl_s1;
         dl_s3 <= dl_s2;
         // A new download starting mid-copy invalidates the buffer: give the
         // bus back and wait for the next falling edge.
         if (state != IDLE && dl_s2) begin
            state        <= IDLE;
            bus.hold_req <= 1'b0;
            bus.mem_we   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
         end else begin
            case (state)
               IDLE: if (trig) begin
                  busy      <= 1'b1;
                  idx       <= '0;
                  truncated <= over;
                  len       <= over ? CAP[LW-1:0] : size_x[LW-1:0];
                  // Empty image: skip the bus hold entirely; passing through
                  // REL keeps the same release/done tail as a real copy.
                  if (size == 16'd0) state <= REL;
                  else begin
                     state        <= REQ;
                     bus.hold_req <= 1'b1;
                  end
               end
               REQ: if (bus.hold_ack) begin
                  state        <= RD;
                  bus.buf_addr <= idx[BUF_AW-1:0];
               end
               RD: state <= WT;
               // buf_dout is valid here, one clk after the address was issued
               WT: begin
                  state        <= WR;
                  bus.mem_we   <= 1'b1;
                  bus.mem_addr <= LOAD_ADDR + 16'(idx);
                  bus.mem_dout <= bus.buf_dout;
               end
               WR: begin
                  bus.mem_we <= 1'b0;
                  idx        <= idx_nx;
                  if (idx_nx == len) begin
                     state        <= REL;
                     bus.hold_req <= 1'b0;
                  end else begin
                     state        <= RD;
                     bus.buf_addr <= idx_nx[BUF_AW-1:0];
                  end
               end
               REL: begin
                  state <= DONE;
                  done  <= 1'b1;
               end
               DONE: begin
                  state <= IDLE;
                  done  <= 1'b0;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pfile_loader.sv
// tb_pfile_loader
//   Directed + randomised bench for pfile_loader. Expected RAM contents come
//   from the copy rule: byte i of the buffer lands at LOAD_ADDR+i for
//   i < min(size, capacity).
module tb_pfile_loader;
   localparam int          AW  = 14;
   localparam int          CAP = 1 << AW;
   localparam logic [15:0] LA  = 16'h4009;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic        downloading;
   logic [15:0] size;
   logic        busy, done, truncated;

   pfile_loader_if #(.BUF_AW(AW)) bus ();

   pfile_loader #(.LOAD_ADDR(LA), .BUF_AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .downloading(downloading), .size(size),
      .bus(bus.master), .busy(busy), .done(done), .truncated(truncated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // download buffer: synchronous read, data one clk after address
   logic [7:0] bufm [CAP];
   always @(posedge clk) bus.buf_dout <= bufm[bus.buf_addr];

   // CPU hold responder: ack after ack_delay clocks, optional noise once acked
   int ack_delay = 2;
   bit ack_noise = 1'b0;
   int acnt = 0;
   always @(posedge clk) begin
      if (!bus.hold_req) begin
         bus.hold_ack <= 1'b0;
         acnt         <= 0;
      end else if (bus.hold_ack && ack_noise)
         bus.hold_ack <= 1'($urandom_range(0, 1));
      else if (acnt >= ack_delay)
         bus.hold_ack <= 1'b1;
      else
         acnt <= acnt + 1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor
   wr_t wq[$];
   bit  clr_req = 1'b0;
   int  dcnt, busy_cyc, hold_cyc, gap_err, nohold_err, last_we, rise_cyc;
   bit  busy_q = 1'b0;
   always @(negedge clk) begin
      if (clr_req) begin
         wq.delete();
         dcnt = 0; busy_cyc = 0; hold_cyc = 0; gap_err = 0; nohold_err = 0;
      end else begin
         if (bus.mem_we) begin
            if (wq.size() > 0 && cyc - last_we != 3) gap_err++;
            if (!bus.hold_req) nohold_err++;
            wq.push_back('{a: bus.mem_addr, d: bus.mem_dout});
            last_we = cyc;
         end
         if (done)         dcnt++;
         if (busy)         busy_cyc++;
         if (bus.hold_req) hold_cyc++;
      end
      if (busy && !busy_q) rise_cyc = cyc;
      busy_q = busy;
   end

   int fall_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic clr;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
   endtask

   task automatic fill_rand;
      for (int i = 0; i < CAP; i++) bufm[i] = 8'($urandom);
   endtask

   task automatic start_dl(input logic [15:0] sz);
      downloading = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      size        = sz;
      downloading = 1'b0;
      fall_cyc    = cyc;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (dcnt == 0 && n < limit) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(dcnt != 0), 1);
      repeat (3) tick();
   endtask

   // reference: writes expected for a completed copy of sz bytes
   task automatic check_writes(input string tag, input int sz);
      int n   = (sz > CAP) ? CAP : sz;
      int bad = 0;
      chk({tag, "_count"}, wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++)
         if (wq[i].a !== 16'(LA + i) || wq[i].d !== bufm[i]) bad++;
      chk({tag, "_data"}, bad, 0);
      chk({tag, "_gap"}, gap_err, 0);
      chk({tag, "_nohold"}, nohold_err, 0);
   endtask

   initial begin
      reset_n     = 1'b1;
      downloading = 1'b0;
      size        = '0;
      #1 reset_n  = 1'b0;
      #2;
      chk("rst_hold",  bus.hold_req, 0);
      chk("rst_we",    bus.mem_we, 0);
      chk("rst_addr",  bus.mem_addr, 0);
      chk("rst_dout",  bus.mem_dout, 0);
      chk("rst_baddr", bus.buf_addr, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_trunc", truncated, 0);
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b1;

      // 1: four bytes
      bufm[0] = 8'h01; bufm[1] = 8'h02; bufm[2] = 8'h03; bufm[3] = 8'h04;
      ack_delay = 2;
      clr();
      start_dl(16'd4);
      wait_done("t1", 100);
      chk("t1_lat",   32'((rise_cyc - fall_cyc) <= 3), 1);
      check_writes("t1", 4);
      chk("t1_a3",    wq.size() > 3 ? wq[3].a : 16'h0, 16'h400C);
      chk("t1_d3",    wq.size() > 3 ? wq[3].d : 8'h0, 8'h04);
      chk("t1_dcnt",  dcnt, 1);
      chk("t1_hold",  bus.hold_req, 0);
      chk("t1_busy",  busy, 0);
      chk("t1_trunc", truncated, 0);

      // 2: empty image
      clr();
      start_dl(16'd0);
      wait_done("t2", 20);
      chk("t2_writes", wq.size(), 0);
      chk("t2_hold",   hold_cyc, 0);
      chk("t2_dcnt",   dcnt, 1);
      chk("t2_busy",   busy_cyc, 2);

      // 3: oversize, clipped to capacity
      fill_rand();
      clr();
      start_dl(16'h5000);
      wait_done("t3", 3 * CAP + 100);
      check_writes("t3", 16'h5000);
      chk("t3_first", wq.size() > 0 ? wq[0].a : 16'h0, 16'h4009);
      chk("t3_last",  wq.size() == CAP ? wq[CAP-1].a : 16'h0, 16'h8008);
      chk("t3_trunc", truncated, 1);
      chk("t3_dcnt",  dcnt, 1);

      // 4: abort after 10 bytes, then a fresh 2-byte download
      fill_rand();
      clr();
      start_dl(16'd100);
      begin
         int n = 0;
         while (wq.size() < 10 && n < 200) begin tick(); n++; end
      end
      chk("t4_reach10", 32'(wq.size() >= 10), 1);
      downloading = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_hold_drop", bus.hold_req, 0);
      chk("t4_we",        bus.mem_we, 0);
      repeat (5) tick();
      chk("t4_busy",   busy, 0);
      chk("t4_nodone", dcnt, 0);
      chk("t4_writes", wq.size(), 10);
      chk("t4_trunc",  truncated, 0);
      clr();
      start_dl(16'd2);
      wait_done("t4b", 50);
      check_writes("t4b", 2);
      chk("t4b_dcnt", dcnt, 1);

      // 5: long ack delay
      ack_delay = 100;
      clr();
      start_dl(16'd3);
      begin
         int n = 0;
         while (!bus.hold_req && n < 10) begin tick(); n++; end
      end
      repeat (90) tick();
      chk("t5_hold",   bus.hold_req, 1);
      chk("t5_busy",   busy, 1);
      chk("t5_nowr",   wq.size(), 0);
      wait_done("t5", 200);
      check_writes("t5", 3);
      chk("t5_dcnt",   dcnt, 1);
      ack_delay = 2;

      // randomised runs with a noisy ack
      ack_noise = 1'b1;
      for (int r = 0; r < 3; r++) begin
         int sz = $urandom_range(1, 60);
         ack_delay = $urandom_range(0, 4);
         fill_rand();
         clr();
         start_dl(16'(sz));
         wait_done("rnd", 3 * sz + 60);
         check_writes("rnd", sz);
         chk("rnd_dcnt", dcnt, 1);
         chk("rnd_hold", bus.hold_req, 0);
      end
      ack_noise = 1'b0;
      ack_delay = 2;

      // 6: async reset mid-copy
      clr();
      start_dl(16'd50);
      begin
         int n = 0;
         while (wq.size() < 5 && n < 100) begin tick(); n++; end
      end
      #2 reset_n = 1'b0;
      #1;
      chk("t6_hold",  bus.hold_req, 0);
      chk("t6_we",    bus.mem_we, 0);
      chk("t6_busy",  busy, 0);
      chk("t6_done",  done, 0);
      chk("t6_addr",  bus.mem_addr, 0);
      chk("t6_dout",  bus.mem_dout, 0);
      chk("t6_baddr", bus.buf_addr, 0);
      #3 reset_n = 1'b1;
      clr();
      repeat (10) tick();
      chk("t6_idle",   busy_cyc, 0);
      chk("t6_nowr",   wq.size(), 0);
      chk("t6_nodone", dcnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
